mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 6, meaning memory address width.
REQ-002 The block SHALL have parameter DW, default 8, meaning memory data width.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports m0_req / m1_req, input, 1, access request per master (m0 = processor, m1 = host loader).
REQ-006 The block SHALL have ports m0_we / m1_we, input, 1, write (1) or read (0) for the pending request.
REQ-007 The block SHALL have ports m0_addr / m1_addr, input, AW, access address.
REQ-008 The block SHALL have ports m0_wdata / m1_wdata, input, DW, write data.
REQ-009 The block SHALL have ports m0_lock / m1_lock, input, 1, keep the grant for the next access.
REQ-010 The block SHALL have ports m0_gnt / m1_gnt, output, 1, master owns the memory port this cycle.
REQ-011 The block SHALL have ports m0_done / m1_done, output, 1, one-cycle access-complete pulse.
REQ-012 The block SHALL have port rdata, output, DW, registered read data, valid while a done pulse is high.
REQ-013 The block SHALL have ports mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, DW) and mem_rdata (input, DW) as the single memory port.

Function
REQ-014 The FSM SHALL have states IDLE, GRANT and DONE, plus registers owner (1 bit) and last (1 bit, last served master).
REQ-015 In IDLE with exactly one req high, the FSM SHALL go to GRANT with owner set to that master.
REQ-016 In IDLE with both req high, owner SHALL be the master not equal to last (round-robin).
REQ-017 In IDLE with no request, the FSM SHALL stay in IDLE.
REQ-018 GRANT SHALL last exactly one cycle; gnt of owner high; mem_addr, mem_wdata and mem_we SHALL be routed combinationally from the owner's inputs.
REQ-019 Outside GRANT, mem_we SHALL be 0 and mem_addr and mem_wdata SHALL be 0.
REQ-020 On the clock edge ending GRANT, rdata SHALL capture mem_rdata (reads and writes alike); last SHALL be set to owner.
REQ-021 DONE SHALL last one cycle with owner's done high; latency SHALL be req sampled at edge t -> gnt in cycle t+1 -> done in cycle t+2.
REQ-022 From DONE, if the owner's lock and req are both high, the FSM SHALL go to GRANT with the same owner, ignoring the other master; otherwise it SHALL go to IDLE.
REQ-023 Deasserting req during GRANT SHALL NOT abort the access; done SHALL still pulse.
REQ-024 Master inputs SHALL be sampled only in GRANT; changes in other states SHALL have no effect on memory.
REQ-025 At most one gnt and one done SHALL be high in any cycle.
REQ-026 Both done outputs SHALL be low outside DONE.

Reset
REQ-027 clr_n low SHALL immediately force state IDLE, owner 0, last 1 (m0 wins first tie), rdata 0, and all gnt, done and mem_we outputs 0.
REQ-028 Reset during GRANT SHALL abort the access with no done pulse, and mem_we SHALL fall without waiting for a clock edge.

Structure
REQ-029 The state encoding (IDLE, GRANT, DONE) and the master index constants SHALL live in a shared package reused by other bus blocks.
REQ-030 The rdata capture SHALL reuse the existing enable-equipped register sub-module (register, width DW); the other logic SHALL be flat.

Verification
REQ-031 Single read: m0_req=1, m0_we=0, m0_addr=0x05, mem_rdata=0xA5 -> m0_gnt in cycle 1, mem_addr=0x05, m0_done with rdata=0xA5 in cycle 2.
REQ-032 Single write: m1 writes 0x3C to 0x2A -> mem_we=1 only in the GRANT cycle, with mem_addr=0x2A and mem_wdata=0x3C.
REQ-033 Contention: both req held high from reset -> grant order m0, m1, m0, m1, with 3 cycles per access and no overlap.
REQ-034 Lock: m1 holds lock and req for 3 accesses while m0 requests -> m1 is granted 3 times consecutively, then m0.
REQ-035 Reset mid-access: clr_n low during m0 GRANT with write -> mem_we drops immediately, no done pulse, IDLE after release.
REQ-036 Request dropped during GRANT -> done still pulses once, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared bus-arbitration types: FSM state encoding and master index
//            constants used by the memory arbiter and other bus blocks.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Arbitration FSM states, with explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  // Master indices (m0 = processor, m1 = host loader)
  localparam logic C_M0 = 1'b0;
  localparam logic C_M1 = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_register.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_register
// Purpose  : Generic enable-equipped register with asynchronous active-low
//            clear. Loads d on a rising clock edge while en is high.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold value unless enabled; clear immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : mem_arbiter_register
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master round-robin arbiter for a single memory port, with
//            per-master lock to keep back-to-back ownership.
//            Access timing: IDLE -> GRANT (1 cycle) -> DONE (1 cycle).
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m0_lock,
  input  logic          m1_lock,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_done,
  output logic          m1_done,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  import mem_arbiter_pkg::*;

  arb_state_e r_state;
  arb_state_e w_next_state;
  logic       r_owner;
  logic       w_next_owner;
  logic       r_last;

  logic          w_own_req;
  logic          w_own_lock;
  logic          w_own_we;
  logic [AW-1:0] w_own_addr;
  logic [DW-1:0] w_own_wdata;
  logic          w_in_grant;
  logic          w_in_done;

  // Current owner's request bundle
  assign w_own_req   = (r_owner == C_M1) ? m1_req   : m0_req;
  assign w_own_lock  = (r_owner == C_M1) ? m1_lock  : m0_lock;
  assign w_own_we    = (r_owner == C_M1) ? m1_we    : m0_we;
  assign w_own_addr  = (r_owner == C_M1) ? m1_addr  : m0_addr;
  assign w_own_wdata = (r_owner == C_M1) ? m1_wdata : m0_wdata;

  assign w_in_grant = (r_state == GRANT);
  assign w_in_done  = (r_state == DONE);

  // State, owner and last-served registers; reset makes m0 win the first tie
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_owner <= C_M0;
      r_last  <= C_M1;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      if (w_in_grant) begin
        r_last <= r_owner;
      end
    end
  end

  // Next-state and owner selection (round-robin on tie, lock keeps owner)
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_next_state = GRANT;
          w_next_owner = ~r_last;
        end else if (m0_req) begin
          w_next_state = GRANT;
          w_next_owner = C_M0;
        end else if (m1_req) begin
          w_next_state = GRANT;
          w_next_owner = C_M1;
        end
      end
      GRANT: begin
        w_next_state = DONE;
      end
      DONE: begin
        if (w_own_lock && w_own_req) begin
          w_next_state = GRANT;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Grant/done strobes and memory-port routing; port is quiet outside GRANT
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_in_grant) begin
      m0_gnt    = (r_owner == C_M0);
      m1_gnt    = (r_owner == C_M1);
      mem_we    = w_own_we;
      mem_addr  = w_own_addr;
      mem_wdata = w_own_wdata;
    end
    if (w_in_done) begin
      m0_done = (r_owner == C_M0);
      m1_done = (r_owner == C_M1);
    end
  end

  // Read data captured on the edge that ends GRANT, for reads and writes
  mem_arbiter_register #(
    .W (DW)
  ) u_rdata_reg (
    .clk   (clk),
    .rst_n (clr_n),
    .i_en  (w_in_grant),
    .i_d   (mem_rdata),
    .o_q   (rdata)
  );

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: table of single accesses
//            plus directed contention, lock and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic       clk;
  logic       clr_n;
  logic       m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [5:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_done, m1_done;
  logic [7:0] rdata;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  mem_arbiter #(.AW(6), .DW(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_done   (m0_done),
    .m1_done   (m1_done),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic       we;
    logic       lock;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] mrdata;
    logic       exp_we;
    logic [5:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input logic m, input logic req, input logic we, input logic lock,
                            input logic [5:0] addr, input logic [7:0] wdata);
    if (m) begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic pulse_reset();
    clr_n = 1'b0;
    #2;
    clr_n = 1'b1;
  endtask

  function automatic logic [3:0] status();
    return {m1_gnt, m0_gnt, m1_done, m0_done};
  endfunction

  // One isolated access from IDLE; the owner drops req during GRANT
  task automatic run_vector(input int i, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", i);
    set_master(v.m, 1'b1, v.we, v.lock, v.addr, v.wdata);
    // Decoy values on the idle master catch a wrong routing mux
    set_master(~v.m, 1'b0, ~v.we, 1'b0, ~v.addr, ~v.wdata);
    mem_rdata = v.mrdata;
    step();
    check({tag, "_gnt"},   {30'd0, m1_gnt, m0_gnt}, v.m ? 32'd2 : 32'd1);
    check({tag, "_we"},    {31'd0, mem_we}, {31'd0, v.exp_we});
    check({tag, "_addr"},  {26'd0, mem_addr}, {26'd0, v.exp_addr});
    check({tag, "_wdata"}, {24'd0, mem_wdata}, {24'd0, v.exp_wdata});
    set_master(v.m, 1'b0, v.we, v.lock, v.addr, v.wdata);
    step();
    check({tag, "_done"},  {30'd0, m1_done, m0_done}, v.m ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, {24'd0, rdata}, {24'd0, v.exp_rdata});
    check({tag, "_quiet"}, {23'd0, mem_we, mem_addr, m1_gnt, m0_gnt}, 32'd0);
    mem_rdata = 8'hEE;
    step();
    check({tag, "_idle"},  {28'd0, status()}, 32'd0);
    check({tag, "_hold"},  {24'd0, rdata}, {24'd0, v.exp_rdata});
    set_master(v.m, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0);
    set_master(~v.m, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0);
    step();
    check({tag, "_stay"},  {28'd0, status()}, 32'd0);
  endtask

  logic [3:0] exp_cont[12];
  logic [3:0] exp_lock[9];

  initial begin
    // m, we, lock, addr, wdata, mrdata | exp_we, exp_addr, exp_wdata, exp_rdata
    vecs[0] = '{1'b0, 1'b0, 1'b0, 6'h05, 8'h77, 8'hA5, 1'b0, 6'h05, 8'h77, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 6'h2A, 8'h3C, 8'h11, 1'b1, 6'h2A, 8'h3C, 8'h11};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'h3F, 8'hFF, 8'h80, 1'b1, 6'h3F, 8'hFF, 8'h80};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 6'h00, 8'h01, 8'h5A, 1'b0, 6'h00, 8'h01, 8'h5A};
    // {m1_gnt, m0_gnt, m1_done, m0_done} per cycle with both masters requesting
    exp_cont = '{4'b0100, 4'b0001, 4'b0000, 4'b1000, 4'b0010, 4'b0000,
                 4'b0100, 4'b0001, 4'b0000, 4'b1000, 4'b0010, 4'b0000};
    // m1 locked for three accesses, then m0
    exp_lock = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010,
                 4'b0000, 4'b0100, 4'b0001};

    clr_n = 1'b0;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_status", {28'd0, status()}, 32'd0);
    check("reset_port",   {17'd0, mem_we, mem_addr, mem_wdata}, 32'd0);
    check("reset_rdata",  {24'd0, rdata}, 32'd0);
    clr_n = 1'b1;
    step();

    foreach (vecs[i]) run_vector(i, vecs[i]);

    // Contention from reset: m0 wins first, then strict alternation
    m0_req = 1'b1; m0_addr = 6'h11;
    m1_req = 1'b1; m1_addr = 6'h22;
    pulse_reset();
    for (int c = 0; c < 12; c++) begin
      step();
      check($sformatf("cont_c%0d", c + 1), {28'd0, status()}, {28'd0, exp_cont[c]});
      if (exp_cont[c][3] || exp_cont[c][2])
        check($sformatf("cont_addr_c%0d", c + 1), {26'd0, mem_addr},
              exp_cont[c][3] ? 32'h22 : 32'h11);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step(); step(); step();

    // Lock: m1 keeps the port for three accesses while m0 waits
    pulse_reset();
    m1_req = 1'b1; m1_lock = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step();
      check($sformatf("lock_c%0d", c + 1), {28'd0, status()}, {28'd0, exp_lock[c]});
      if (c == 0) m0_req = 1'b1;
      if (c == 4) begin m1_req = 1'b0; m1_lock = 1'b0; end
      if (c == 7) m0_req = 1'b0;
    end
    step();
    check("lock_end_idle", {28'd0, status()}, 32'd0);

    // Reset during an m0 write GRANT aborts the access
    pulse_reset();
    mem_rdata = 8'hC3;
    set_master(1'b0, 1'b1, 1'b1, 1'b0, 6'h15, 8'h9D);
    step();
    check("rst_pre_we", {31'd0, mem_we}, 32'd1);
    #2;
    clr_n = 1'b0;
    #1;
    check("rst_we_drop", {31'd0, mem_we}, 32'd0);
    check("rst_gnt_drop", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    step();
    check("rst_no_done", {30'd0, m1_done, m0_done}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    m0_req = 1'b0;
    clr_n = 1'b1;
    step();
    check("rst_idle1", {28'd0, status()}, 32'd0);
    step();
    check("rst_idle2", {28'd0, {mem_we, status()}}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
